// File: rtl/cpureg_wide_arb.sv
// Shares one wide indirect-register expansion bus among NREQ requesters with timeout abort.
// Define CPUREG_WIDE_ARB_FIXPRI_EN for fixed priority (lowest index wins); default is round-robin.
module cpureg_wide_arb #(
  parameter int BUSWIDTH = 128,
  parameter int NREQ     = 2,
  parameter int TOUTW    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_ws,
  input  logic [NREQ-1:0]          req_rs,
  input  logic [NREQ*BUSWIDTH-1:0] req_di,
  output logic [NREQ-1:0]          req_rdy,
  output logic [NREQ-1:0]          req_err,
  output logic [BUSWIDTH-1:0]      req_do,
  output logic                     upws_e,
  output logic                     uprs_e,
  output logic [BUSWIDTH-1:0]      updi_e,
  input  logic                     uprdy_e,
  input  logic [BUSWIDTH-1:0]      updo_e,
  input  logic [TOUTW-1:0]         tout_cfg,
  output logic [NREQ-1:0]          gnt
);

  // state | meaning
  // IDLE  | sample pending strobes, pick a winner, launch the expansion access
  // WAIT  | expansion strobe held, waiting for uprdy_e or timeout
  // RESP  | one-cycle req_rdy/req_err to the winner, release grant

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t               state, state_n;
  logic [PTRW-1:0]      gidx, gidx_n;
  logic [TOUTW-1:0]     cnt, cnt_n;
  logic [NREQ-1:0]      gnt_n, req_rdy_n, req_err_n;
  logic                 upws_n, uprs_n;
  logic [BUSWIDTH-1:0]  updi_n, req_do_n;

  logic [NREQ-1:0]      pend;
  logic [PTRW:0]        srch;
  logic                 win_vld;
  logic [PTRW-1:0]      win_idx;
  logic [NREQ-1:0]      win_oh;
  logic [BUSWIDTH-1:0]  win_di;
  logic                 tout_hit;

`ifndef CPUREG_WIDE_ARB_FIXPRI_EN
  logic [PTRW-1:0]      ptr, ptr_n;
`endif

  // Winner search: circular from ptr, or from index 0 in fixed-priority builds.
  always_comb begin
    pend    = req_ws | req_rs;
    win_vld = 1'b0;
    win_idx = '0;
    srch    = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef CPUREG_WIDE_ARB_FIXPRI_EN
      srch = (PTRW+1)'(k);
`else
      srch = {1'b0, ptr} + (PTRW+1)'(k);
      if (srch >= (PTRW+1)'(NREQ))
        srch = srch - (PTRW+1)'(NREQ);
`endif
      if (!win_vld && pend[srch[PTRW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = srch[PTRW-1:0];
      end
    end
  end

  always_comb begin
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
    win_di          = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PTRW'(i))
        win_di = req_di[i*BUSWIDTH +: BUSWIDTH];
    end
  end

  assign tout_hit = (tout_cfg != '0) && (cnt == tout_cfg);

  always_comb begin
    state_n   = state;
    gidx_n    = gidx;
    cnt_n     = cnt;
    gnt_n     = gnt;
    upws_n    = upws_e;
    uprs_n    = uprs_e;
    updi_n    = updi_e;
    req_rdy_n = req_rdy;
    req_err_n = req_err;
    req_do_n  = req_do;
`ifndef CPUREG_WIDE_ARB_FIXPRI_EN
    ptr_n     = ptr;
`endif
    case (state)
      ST_IDLE: begin
        upws_n = 1'b0;
        uprs_n = 1'b0;
        if (win_vld) begin
          gnt_n   = win_oh;
          gidx_n  = win_idx;
          updi_n  = win_di;
          upws_n  = req_ws[win_idx];
          uprs_n  = !req_ws[win_idx];
          cnt_n   = '0;
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Ready has priority over a timeout landing in the same cycle.
        if (uprdy_e) begin
          upws_n          = 1'b0;
          uprs_n          = 1'b0;
          req_do_n        = uprs_e ? updo_e : '0;
          req_rdy_n[gidx] = 1'b1;
          state_n         = ST_RESP;
        end else if (tout_hit) begin
          upws_n          = 1'b0;
          uprs_n          = 1'b0;
          req_do_n        = '1;
          req_rdy_n[gidx] = 1'b1;
          req_err_n[gidx] = 1'b1;
          state_n         = ST_RESP;
        end else if (cnt != '1) begin
          cnt_n = cnt + TOUTW'(1);
        end
      end
      ST_RESP: begin
        req_rdy_n = '0;
        req_err_n = '0;
        gnt_n     = '0;
`ifndef CPUREG_WIDE_ARB_FIXPRI_EN
        ptr_n     = (gidx == PTRW'(NREQ-1)) ? '0 : gidx + PTRW'(1);
`endif
        state_n   = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      gidx    <= '0;
      cnt     <= '0;
      gnt     <= '0;
      upws_e  <= 1'b0;
      uprs_e  <= 1'b0;
      updi_e  <= '0;
      req_rdy <= '0;
      req_err <= '0;
      req_do  <= '0;
`ifndef CPUREG_WIDE_ARB_FIXPRI_EN
      ptr     <= '0;
`endif
    end else begin
      state   <= state_n;
      gidx    <= gidx_n;
      cnt     <= cnt_n;
      gnt     <= gnt_n;
      upws_e  <= upws_n;
      uprs_e  <= uprs_n;
      updi_e  <= updi_n;
      req_rdy <= req_rdy_n;
      req_err <= req_err_n;
      req_do  <= req_do_n;
`ifndef CPUREG_WIDE_ARB_FIXPRI_EN
      ptr     <= ptr_n;
`endif
    end
  end

endmodule

// File: tb/tb_cpureg_wide_arb.sv
// Directed bench for cpureg_wide_arb: reads, writes, arbitration order, timeout, races, reset.
module tb_cpureg_wide_arb;
  localparam int BW = 128;
  localparam int NR = 2;
  localparam int TW = 8;

  localparam logic [BW-1:0] RD_VAL  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [BW-1:0] DI0     = 128'hAAAA_0000_1111_2222_3333_4444_5555_0000;
  localparam logic [BW-1:0] DI1     = 128'hBBBB_9999_8888_7777_6666_5555_4444_0001;
  localparam logic [BW-1:0] RACE_V  = 128'hDEAD_BEEF_0000_0000_CAFE_F00D_1234_5678;
  localparam logic [BW-1:0] ALL1    = {BW{1'b1}};

  logic              clk, rst_n;
  logic [NR-1:0]     req_ws, req_rs, req_rdy, req_err, gnt;
  logic [NR*BW-1:0]  req_di;
  logic [BW-1:0]     req_do, updi_e, updo_e;
  logic              upws_e, uprs_e, uprdy_e;
  logic [TW-1:0]     tout_cfg;

  int errors = 0;
  int checks = 0;

  cpureg_wide_arb #(.BUSWIDTH(BW), .NREQ(NR), .TOUTW(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_ws(req_ws), .req_rs(req_rs), .req_di(req_di),
    .req_rdy(req_rdy), .req_err(req_err), .req_do(req_do),
    .upws_e(upws_e), .uprs_e(uprs_e), .updi_e(updi_e),
    .uprdy_e(uprdy_e), .updo_e(updo_e),
    .tout_cfg(tout_cfg), .gnt(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0; req_ws = '0; req_rs = '0; uprdy_e = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_ws = '0; req_rs = '0; uprdy_e = 1'b0;
    updo_e = '0; tout_cfg = '0; req_di = {DI1, DI0};
    #3;
    checks++;
    if ({gnt, upws_e, uprs_e, req_rdy, req_err} !== '0) begin
      errors++; $display("FAIL reset_ctl: got gnt=%b ws=%b rs=%b rdy=%b err=%b, expected all 0",
                         gnt, upws_e, uprs_e, req_rdy, req_err);
    end
    checks++;
    if (updi_e !== '0 || req_do !== '0) begin
      errors++; $display("FAIL reset_data: got updi_e=%h req_do=%h, expected 0", updi_e, req_do);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_ignore();
    uprdy_e = 1'b1; updo_e = RD_VAL;
    repeat (2) @(negedge clk);
    checks++;
    if (req_rdy !== 2'b00 || gnt !== 2'b00 || upws_e !== 1'b0 || uprs_e !== 1'b0) begin
      errors++; $display("FAIL idle_uprdy: got rdy=%b gnt=%b ws=%b rs=%b, expected all 0",
                         req_rdy, gnt, upws_e, uprs_e);
    end
    uprdy_e = 1'b0;
  endtask

  task automatic test_single_read();
    tout_cfg = '0;
    req_rs = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (uprs_e !== 1'b1 || upws_e !== 1'b0 || gnt !== 2'b01) begin
        errors++; $display("FAIL rd_strobe%0d: got rs=%b ws=%b gnt=%b, expected rs=1 ws=0 gnt=01",
                           k, uprs_e, upws_e, gnt);
      end
    end
    uprdy_e = 1'b1; updo_e = RD_VAL;
    @(negedge clk);
    uprdy_e = 1'b0; updo_e = '0;
    checks++;
    if (uprs_e !== 1'b0 || req_rdy !== 2'b01 || req_err !== 2'b00) begin
      errors++; $display("FAIL rd_done: got rs=%b rdy=%b err=%b, expected rs=0 rdy=01 err=00",
                         uprs_e, req_rdy, req_err);
    end
    checks++;
    if (req_do !== RD_VAL) begin
      errors++; $display("FAIL rd_data: got %h expected %h", req_do, RD_VAL);
    end
    req_rs = 2'b00;
    @(negedge clk);
    checks++;
    if (req_rdy !== 2'b00 || gnt !== 2'b00 || req_do !== RD_VAL) begin
      errors++; $display("FAIL rd_release: got rdy=%b gnt=%b do=%h, expected rdy=00 gnt=00 do=%h",
                         req_rdy, gnt, req_do, RD_VAL);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int exp_i;
    logic [NR-1:0]  exp_oh;
    logic [BW-1:0]  exp_di;
    do_reset();
    tout_cfg = '0;
    req_di = {DI1, DI0};
    req_ws = 2'b11;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      @(negedge clk);
      while (gnt === 2'b00 && n < 10) begin
        n++;
        @(negedge clk);
      end
`ifdef CPUREG_WIDE_ARB_FIXPRI_EN
      exp_i = 0;
`else
      exp_i = g % 2;
`endif
      exp_oh = (exp_i == 0) ? 2'b01 : 2'b10;
      exp_di = (exp_i == 0) ? DI0 : DI1;
      checks++;
      if (n !== ((g == 0) ? 0 : 1)) begin
        errors++; $display("FAIL rr_spacing%0d: idle cycles before grant %0d, expected %0d",
                           g, n, (g == 0) ? 0 : 1);
      end
      checks++;
      if (gnt !== exp_oh || upws_e !== 1'b1 || uprs_e !== 1'b0) begin
        errors++; $display("FAIL rr_grant%0d: got gnt=%b ws=%b rs=%b, expected gnt=%b ws=1 rs=0",
                           g, gnt, upws_e, uprs_e, exp_oh);
      end
      checks++;
      if (updi_e !== exp_di) begin
        errors++; $display("FAIL rr_updi%0d: got %h expected %h", g, updi_e, exp_di);
      end
      uprdy_e = 1'b1; updo_e = RD_VAL;
      @(negedge clk);
      uprdy_e = 1'b0;
      checks++;
      if (req_rdy !== exp_oh || req_do !== '0) begin
        errors++; $display("FAIL rr_rdy%0d: got rdy=%b do=%h, expected rdy=%b do=0",
                           g, req_rdy, req_do, exp_oh);
      end
    end
    req_ws = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    logic [TW-1:0] tv [3];
    tv[0] = 8'd5; tv[1] = 8'd1; tv[2] = 8'd3;
    for (int t = 0; t < 3; t++) begin
      tout_cfg = tv[t];
      req_rs = 2'b10;
      n = 0;
      @(negedge clk);
      while (uprs_e === 1'b1 && n < 300) begin
        n++;
        @(negedge clk);
      end
      checks++;
      if (n !== int'(tv[t]) + 1) begin
        errors++; $display("FAIL to_len%0d: strobe cycles %0d, expected %0d", t, n, int'(tv[t]) + 1);
      end
      checks++;
      if (req_rdy !== 2'b10 || req_err !== 2'b10 || req_do !== ALL1) begin
        errors++; $display("FAIL to_abort%0d: got rdy=%b err=%b do=%h, expected rdy=10 err=10 do=all ones",
                           t, req_rdy, req_err, req_do);
      end
      req_rs = 2'b00;
      @(negedge clk);
      checks++;
      if (req_rdy !== 2'b00 || req_err !== 2'b00) begin
        errors++; $display("FAIL to_pulse%0d: got rdy=%b err=%b, expected 00 00", t, req_rdy, req_err);
      end
    end
    tout_cfg = '0;
    req_rs = 2'b01;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (uprs_e === 1'b1 && req_rdy === 2'b00) n++;
    end
    checks++;
    if (n !== 40) begin
      errors++; $display("FAIL to_disabled: strobe held %0d of 40 cycles, expected 40", n);
    end
    uprdy_e = 1'b1; updo_e = DI1;
    @(negedge clk);
    uprdy_e = 1'b0;
    checks++;
    if (req_rdy !== 2'b01 || req_err !== 2'b00 || req_do !== DI1) begin
      errors++; $display("FAIL to_dis_done: got rdy=%b err=%b do=%h, expected rdy=01 err=00 do=%h",
                         req_rdy, req_err, req_do, DI1);
    end
    req_rs = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_race();
    int n;
    tout_cfg = 8'd4;
    req_rs = 2'b01;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (uprs_e === 1'b1) n++;
    end
    checks++;
    if (n !== 5) begin
      errors++; $display("FAIL race_len: strobe cycles %0d, expected 5", n);
    end
    uprdy_e = 1'b1; updo_e = RACE_V;
    @(negedge clk);
    uprdy_e = 1'b0;
    checks++;
    if (req_rdy !== 2'b01 || req_err !== 2'b00 || req_do !== RACE_V) begin
      errors++; $display("FAIL race_done: got rdy=%b err=%b do=%h, expected rdy=01 err=00 do=%h",
                         req_rdy, req_err, req_do, RACE_V);
    end
    req_rs = 2'b00;
    tout_cfg = '0;
    @(negedge clk);
  endtask

  task automatic test_ws_rs();
    req_ws = 2'b10; req_rs = 2'b10;
    @(negedge clk);
    checks++;
    if (upws_e !== 1'b1 || uprs_e !== 1'b0 || gnt !== 2'b10 || updi_e !== DI1) begin
      errors++; $display("FAIL wsrs_strobe: got ws=%b rs=%b gnt=%b di=%h, expected ws=1 rs=0 gnt=10 di=%h",
                         upws_e, uprs_e, gnt, updi_e, DI1);
    end
    uprdy_e = 1'b1; updo_e = RACE_V;
    @(negedge clk);
    uprdy_e = 1'b0;
    checks++;
    if (req_rdy !== 2'b10 || req_do !== '0) begin
      errors++; $display("FAIL wsrs_done: got rdy=%b do=%h, expected rdy=10 do=0", req_rdy, req_do);
    end
    req_ws = 2'b00; req_rs = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    // Complete one access on requester 0 so the round-robin pointer points at 1.
    req_ws = 2'b01;
    @(negedge clk);
    uprdy_e = 1'b1;
    @(negedge clk);
    uprdy_e = 1'b0; req_ws = 2'b00;
    @(negedge clk);
    req_rs = 2'b10;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b10 || uprs_e !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got gnt=%b rs=%b, expected gnt=10 rs=1", gnt, uprs_e);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, upws_e, uprs_e, req_rdy, req_err} !== '0 || updi_e !== '0 || req_do !== '0) begin
      errors++; $display("FAIL mid_reset: got gnt=%b ws=%b rs=%b rdy=%b err=%b di=%h do=%h, expected all 0",
                         gnt, upws_e, uprs_e, req_rdy, req_err, updi_e, req_do);
    end
    req_rs = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b01 || uprs_e !== 1'b1) begin
      errors++; $display("FAIL mid_ptr0: got gnt=%b rs=%b, expected gnt=01 rs=1", gnt, uprs_e);
    end
    uprdy_e = 1'b1; updo_e = RD_VAL;
    @(negedge clk);
    uprdy_e = 1'b0;
    checks++;
    if (req_rdy !== 2'b01 || req_do !== RD_VAL) begin
      errors++; $display("FAIL mid_done: got rdy=%b do=%h, expected rdy=01 do=%h", req_rdy, req_do, RD_VAL);
    end
    req_rs = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_race();
    test_ws_rs();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
